// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared state encoding, word size and address checking for mem_responder
package mem_resp_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam int unsigned WORD_BYTES = 4;
    function automatic logic addr_err(input logic [31:0] a, input int unsigned depth);
        return (a[1:0] != 2'b00) || (a >= 32'(WORD_BYTES * depth));
    endfunction
endpackage

// File: rtl/mem_word_ram.sv
// mem_word_ram: single-port word array with synchronous write and registered read, no reset
module mem_word_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW = 6
) (
    input  logic          clock,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];
    always_ff @(posedge clock) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: valid/ready memory slave with fixed latency, one outstanding request, error response
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned LAT = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);
    localparam int unsigned AW = $clog2(DEPTH);
    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic fire, acc, acc_err, rd_seen, we_q, err_q, ram_we, ram_re, ram_wr;
    logic [AW-1:0] wa_q, ram_a;
    logic [31:0] wd_q, ram_wd, ram_q;
    assign acc = (state == IDLE) && req_valid;
    assign acc_err = addr_err(req_addr, DEPTH);
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        fire = 1'b0;
        case (state)
            IDLE: if (req_valid) begin
                if (acc_err) state_n = RESP;
                else if (LAT == 1) begin
                    state_n = RESP;
                    fire = 1'b1;
                end else begin
                    state_n = WAIT;
                    cnt_n = 4'(LAT - 1);
                end
            end
            WAIT: if (cnt == 4'd1) begin
                state_n = RESP;
                fire = 1'b1;
            end else cnt_n = cnt - 4'd1;
            default: state_n = IDLE;
        endcase
    end
    // With LAT==1 the array is accessed on the accept edge, before capture, so use the live request
    assign ram_a  = (state == IDLE) ? req_addr[AW+1:2] : wa_q;
    assign ram_wd = (state == IDLE) ? req_wdata : wd_q;
    assign ram_wr = (state == IDLE) ? req_we : we_q;
    assign ram_we = fire && ram_wr;
    assign ram_re = fire && !ram_wr;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            wa_q <= '0;
            wd_q <= '0;
            we_q <= 1'b0;
            err_q <= 1'b0;
            rd_seen <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            if (acc) begin
                wa_q <= req_addr[AW+1:2];
                wd_q <= req_wdata;
                we_q <= req_we;
                err_q <= acc_err;
            end
            if (ram_re) rd_seen <= 1'b1;
        end
    end
    mem_word_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clock(clock),
        .we(ram_we),
        .re(ram_re),
        .addr(ram_a),
        .wdata(ram_wd),
        .rdata(ram_q)
    );
    // The array register is not reset, so read data is masked to zero until a read has landed
    assign rsp_rdata = rd_seen ? ram_q : '0;
    assign req_ready = state == IDLE;
    assign busy = state != IDLE;
    assign rsp_valid = state == RESP;
    assign rsp_err = rsp_valid && err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of mem_responder at LAT 2, 3, 1 and 15
module tb_mem_responder;
    logic clock = 1'b0, reset = 1'b1, wen = 1'b0;
    logic [3:0] vld = '0, rdy, rv, rerr, bsy;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rd [4];
    int errors = 0, checks = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mem_responder #(.DEPTH(64), .LAT(g == 0 ? 2 : g == 1 ? 3 : g == 2 ? 1 : 15)) u_dut (
            .clock(clock), .reset(reset), .req_valid(vld[g]), .req_we(wen),
            .req_addr(addr), .req_wdata(wdata), .req_ready(rdy[g]), .rsp_valid(rv[g]),
            .rsp_rdata(rd[g]), .rsp_err(rerr[g]), .busy(bsy[g]));
    end

    task automatic txn(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic e, output logic [31:0] q,
                       output logic rdy_rsp, output logic rdy_end);
        addr = a; wdata = wd; wen = we; vld[d] = 1'b1;
        @(negedge clock);
        vld[d] = 1'b0;
        lat = 1;
        while (!rv[d] && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        if (!rv[d]) lat = -1;
        e = rerr[d]; q = rd[d]; rdy_rsp = rdy[d];
        @(negedge clock);
        rdy_end = rdy[d];
    endtask

    task automatic test_reset();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if ({rdy[d], rv[d], rerr[d], bsy[d]} !== 4'b1000 || rd[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset[%0d]: rdy/rv/err/busy=%b rdata=%h want 1000 00000000", d, {rdy[d], rv[d], rerr[d], bsy[d]}, rd[d]);
            end
        end
    endtask

    task automatic test_write_read();
        int lat; logic e, r1, r2; logic [31:0] q;
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, lat, e, q, r1, r2);
        checks++;
        if (lat !== 2 || e !== 1'b0 || q !== 32'h0) begin
            errors++;
            $display("FAIL write_0x10: lat=%0d err=%b rdata=%h want 2 0 00000000", lat, e, q);
        end
        checks++;
        if (r1 !== 1'b0 || r2 !== 1'b1) begin
            errors++;
            $display("FAIL write_ready: rsp=%b after=%b want 0 1", r1, r2);
        end
        txn(0, 1'b0, 32'h10, 32'h0, lat, e, q, r1, r2);
        checks++;
        if (lat !== 2 || e !== 1'b0 || q !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_0x10: lat=%0d err=%b rdata=%h want 2 0 deadbeef", lat, e, q);
        end
    endtask

    task automatic test_misaligned();
        int lat; logic e, r1, r2; logic [31:0] q;
        txn(0, 1'b0, 32'h13, 32'h0, lat, e, q, r1, r2);
        checks++;
        if (lat !== 1 || e !== 1'b1 || q !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL misaligned_read: lat=%0d err=%b rdata=%h want 1 1 deadbeef", lat, e, q);
        end
        checks++;
        if (r2 !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_ready: got %b want 1", r2);
        end
        txn(0, 1'b1, 32'h12, 32'h0, lat, e, q, r1, r2);
        checks++;
        if (lat !== 1 || e !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_write: lat=%0d err=%b want 1 1", lat, e);
        end
        txn(0, 1'b0, 32'h10, 32'h0, lat, e, q, r1, r2);
        checks++;
        if (e !== 1'b0 || q !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL misaligned_untouched: err=%b rdata=%h want 0 deadbeef", e, q);
        end
    endtask

    task automatic test_range();
        int lat; logic e, r1, r2; logic [31:0] q;
        txn(0, 1'b1, 32'h0, 32'h11111111, lat, e, q, r1, r2);
        txn(0, 1'b1, 32'hFC, 32'hCAFEF00D, lat, e, q, r1, r2);
        txn(0, 1'b1, 32'h100, 32'h00000BAD, lat, e, q, r1, r2);
        checks++;
        if (lat !== 1 || e !== 1'b1) begin
            errors++;
            $display("FAIL range_write_0x100: lat=%0d err=%b want 1 1", lat, e);
        end
        txn(0, 1'b0, 32'h0, 32'h0, lat, e, q, r1, r2);
        checks++;
        if (lat !== 2 || e !== 1'b0 || q !== 32'h11111111) begin
            errors++;
            $display("FAIL range_read_0x00: lat=%0d err=%b rdata=%h want 2 0 11111111", lat, e, q);
        end
        txn(0, 1'b0, 32'hFC, 32'h0, lat, e, q, r1, r2);
        checks++;
        if (lat !== 2 || e !== 1'b0 || q !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL range_read_0xfc: lat=%0d err=%b rdata=%h want 2 0 cafef00d", lat, e, q);
        end
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        wen = 1'b0;
        vld[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (rdy[0] !== (i % 3 == 0) || bsy[0] !== (i % 3 != 0)) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: rdy=%b busy=%b want %b %b", i, rdy[0], bsy[0], i % 3 == 0, i % 3 != 0);
            end
            if (rdy[0]) acc++;
            if (i % 3 == 0) addr = ((i / 3) % 2) ? 32'h0 : 32'h10;
            if (i % 3 == 2) begin
                checks++;
                if (rv[0] !== 1'b1 || rd[0] !== (((i / 3) % 2) ? 32'h11111111 : 32'hDEADBEEF)) begin
                    errors++;
                    $display("FAIL b2b_rsp[%0d]: rv=%b rdata=%h", i, rv[0], rd[0]);
                end
            end
            @(negedge clock);
        end
        vld[0] = 1'b0;
        checks++;
        if (acc !== 4) begin
            errors++;
            $display("FAIL b2b_accepts: got %0d want 4", acc);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        int lat; logic e, r1, r2; logic [31:0] q;
        txn(1, 1'b1, 32'h20, 32'hAAAA5555, lat, e, q, r1, r2);
        txn(1, 1'b0, 32'h20, 32'h0, lat, e, q, r1, r2);
        checks++;
        if (lat !== 3 || q !== 32'hAAAA5555) begin
            errors++;
            $display("FAIL lat3_read: lat=%0d rdata=%h want 3 aaaa5555", lat, q);
        end
        addr = 32'h20; wdata = 32'h12345678; wen = 1'b1; vld[1] = 1'b1;
        @(negedge clock);
        vld[1] = 1'b0;
        checks++;
        if (bsy[1] !== 1'b1) begin
            errors++;
            $display("FAIL mid_accept: busy=%b want 1", bsy[1]);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({rdy[1], rv[1], rerr[1], bsy[1]} !== 4'b1000 || rd[1] !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: rdy/rv/err/busy=%b rdata=%h want 1000 00000000", {rdy[1], rv[1], rerr[1], bsy[1]}, rd[1]);
        end
        @(negedge clock);
        reset = 1'b0;
        txn(1, 1'b0, 32'h20, 32'h0, lat, e, q, r1, r2);
        checks++;
        if (lat !== 3 || e !== 1'b0 || q !== 32'hAAAA5555) begin
            errors++;
            $display("FAIL mid_discard: lat=%0d err=%b rdata=%h want 3 0 aaaa5555", lat, e, q);
        end
    endtask

    task automatic test_lat1();
        int lat; logic e, r1, r2; logic [31:0] q;
        txn(2, 1'b1, 32'h40, 32'h0F0F0F0F, lat, e, q, r1, r2);
        txn(2, 1'b0, 32'h40, 32'h0, lat, e, q, r1, r2);
        checks++;
        if (lat !== 1 || e !== 1'b0 || q !== 32'h0F0F0F0F) begin
            errors++;
            $display("FAIL lat1_read: lat=%0d err=%b rdata=%h want 1 0 0f0f0f0f", lat, e, q);
        end
        checks++;
        if (r1 !== 1'b0 || r2 !== 1'b1) begin
            errors++;
            $display("FAIL lat1_ready: rsp=%b after=%b want 0 1", r1, r2);
        end
    endtask

    task automatic test_lat15();
        int lat; logic e, r1, r2; logic [31:0] q;
        txn(3, 1'b1, 32'h8, 32'h00005A5A, lat, e, q, r1, r2);
        checks++;
        if (lat !== 15 || e !== 1'b0) begin
            errors++;
            $display("FAIL lat15_write: lat=%0d err=%b want 15 0", lat, e);
        end
        txn(3, 1'b0, 32'h8, 32'h0, lat, e, q, r1, r2);
        checks++;
        if (lat !== 15 || q !== 32'h00005A5A || r2 !== 1'b1) begin
            errors++;
            $display("FAIL lat15_read: lat=%0d rdata=%h ready=%b want 15 00005a5a 1", lat, q, r2);
        end
    endtask

    initial begin
        repeat (2) @(negedge clock);
        test_reset();
        reset = 1'b0;
        @(negedge clock);
        test_write_read();
        test_misaligned();
        test_range();
        test_back_to_back();
        test_reset_mid();
        test_lat1();
        test_lat15();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle datapath's memory port: it accepts one word read or write request at a time from the control unit / datapath (address selected by IouD, write enable from EscreveMem), waits a parameterised latency, then returns a one-cycle response with read data or an error flag. It is the slave end of the same memory handshake the control unit currently paces with fixed wait states, letting the FSM move to a valid/ready protocol. It sits between the datapath address/data muxes and the word RAM, and its error output feeds the exception path (Cause/EPC).

## Interface
Parameters:
- DEPTH, 64: number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH-1.
- LAT, 2: cycles from request acceptance to response, legal range 1..15.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high.
- req_valid  input  1  request present.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address.
- req_wdata  input  32  write data.
- req_ready  output  1  responder can accept; high only in IDLE.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  read data; meaningful only with rsp_valid and read.
- rsp_err  output  1  request rejected (misaligned or out of range); meaningful only with rsp_valid.
- busy  output  1  request outstanding (state != IDLE).

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. If req_valid, capture we/addr/wdata at the edge (the accept edge).
  - Error check at accept: err = (req_addr[1:0] != 0) or (req_addr >= 4*DEPTH). On error go to RESP directly, regardless of LAT; no array access.
  - Otherwise, if LAT==1 go to RESP, else go to WAIT with the counter loaded to LAT-1.
- WAIT: decrement the counter each cycle; when it reaches 1, go to RESP on that edge.
- Edge entering RESP (non-error): a write commits wdata to word addr[log2(DEPTH)+1:2]; a read registers the array word into rsp_rdata.
- RESP: rsp_valid=1, rsp_err=captured err, then unconditionally IDLE. req_ready=0 in RESP, so back-to-back requests are spaced LAT+1 cycles.
- Single outstanding request; a read after a write to the same word returns the new data.
- rsp_rdata holds its last value outside RESP. On a write or error response it is unchanged.
- Requests while req_ready=0 are ignored; the requester must hold req_valid until accepted.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0, counter 0. Array contents are not reset.
- Reset mid-operation: return to IDLE immediately. A write not yet committed (before the RESP entry edge) is discarded. No response is issued.
- Latency: accept at edge T, so rsp_valid is high during cycle T+LAT (error: T+1). req_ready returns high in cycle T+LAT+1 (error: T+2).
- Outputs are registered; no combinational path from the req_* inputs to the rsp_* outputs. req_ready is a decode of the state only.
- Address arithmetic is unsigned 32-bit. An address at exactly 4*DEPTH is an error; the address 4*DEPTH-4 is the last legal word.

## Structure
- Package mem_resp_pkg: state typedef enum logic [1:0] {IDLE, WAIT, RESP}; constant WORD_BYTES=4; a function for alignment/range checking.
- Sub-module mem_word_ram: DEPTH x 32 array with synchronous write and registered read, one port, no reset.
- The top level holds the FSM, the 4-bit latency counter, and the capture registers.

## Test plan
- Write 0xDEADBEEF to addr 0x10, LAT=2. Then read 0x10: write rsp_valid at T+2 with err=0; read rsp_rdata=0xDEADBEEF at T+2.
- Misaligned read at addr 0x13: rsp_valid at T+1, rsp_err=1, rsp_rdata unchanged, array untouched.
- Out of range with DEPTH=64: write to 0x100 gives err=1; a subsequent read of 0x00 is unaffected. Read of 0xFC is accepted with err=0.
- Hold req_valid high continuously with alternating addresses: exactly one accept every LAT+1 cycles, and req_ready is low during WAIT/RESP.
- Assert reset one cycle after accepting a write of 0x12345678 to 0x20 (LAT=3): outputs go to reset values immediately, and a later read of 0x20 returns the prior contents.
- LAT=1: read accepted at T gives rsp_valid at T+1 and req_ready at T+2. Repeat with LAT=15 and check rsp_valid at T+15.
